// File: rtl/irq_sched_pkg.sv
// Shared types and width helpers for the IRQ pulse scheduler.
package irq_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap
  } state_e;

  function automatic int unsigned src_w(input int unsigned num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  function automatic int unsigned line_w(input int unsigned num_irq);
    return (num_irq > 1) ? $clog2(num_irq) : 1;
  endfunction

  // Counter only ever holds len-1 for the longer of the two phases.
  function automatic int unsigned cnt_w(input int unsigned pulse_len, input int unsigned gap_len);
    int unsigned m;
    m = (pulse_len > gap_len) ? pulse_len : gap_len;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-index-wins priority encoder with a valid flag.
module prio_enc_lsb #(
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  assign valid_o = |req_i;

  always_comb begin
    idx_o = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_pulse_scheduler.sv
// Latches rising-edge events per source and serialises them as fixed-length IRQ pulses
// on a per-source CPU IRQ line, with a forced idle gap after every pulse.
module irq_pulse_scheduler
  import irq_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter int unsigned NUM_IRQ   = 4,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   src_i,
  input  logic [NUM_SRC-1:0]                   en_i,
  input  logic [NUM_SRC*line_w(NUM_IRQ)-1:0]   map_i,
  input  logic                                 ovf_clr_i,
  output logic [NUM_IRQ-1:0]                   irq_o,
  output logic [NUM_SRC-1:0]                   pending_o,
  output logic [NUM_SRC-1:0]                   ovf_o,
  output logic                                 busy_o,
  output logic [src_w(NUM_SRC)-1:0]            active_src_o
);

  localparam int unsigned SrcW  = src_w(NUM_SRC);
  localparam int unsigned LineW = line_w(NUM_IRQ);
  localparam int unsigned CntW  = cnt_w(PULSE_LEN, GAP_LEN);

  localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE_LEN - 1);
  localparam logic [CntW-1:0] GapLoad   = (GAP_LEN > 0) ? CntW'(GAP_LEN - 1) : '0;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] ovf_q, ovf_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SrcW-1:0]    active_q, active_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic               busy_q, busy_d;

  logic               enc_valid;
  logic [SrcW-1:0]    enc_idx;
  logic [LineW-1:0]   sel_line;

  assign rise     = src_i & ~src_q & en_i;
  assign eligible = pending_q & en_i;

  prio_enc_lsb #(
    .Width (NUM_SRC),
    .IdxW  (SrcW)
  ) u_prio_enc (
    .req_i   (eligible),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  always_comb begin
    sel_line = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (enc_idx == SrcW'(i)) begin
        sel_line = map_i[i*LineW +: LineW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    irq_d    = irq_q;
    grant    = '0;
    unique case (state_q)
      StIdle: begin
        if (enc_valid) begin
          for (int i = 0; i < int'(NUM_SRC); i++) begin
            grant[i] = (enc_idx == SrcW'(i));
          end
          // The line is captured here so later map_i changes cannot move a live pulse.
          for (int j = 0; j < int'(NUM_IRQ); j++) begin
            irq_d[j] = (sel_line == LineW'(j));
          end
          state_d  = StPulse;
          cnt_d    = PulseLoad;
          active_d = enc_idx;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          irq_d = '0;
          if (GAP_LEN == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        irq_d   = '0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // A rise landing on the bit being granted re-arms it rather than counting as overflow.
  always_comb begin
    pending_d = (pending_q & ~grant) | rise;
    ovf_d     = (ovf_clr_i ? '0 : ovf_q) | (rise & pending_q & ~grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      src_q     <= src_i;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      active_q <= '0;
      irq_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      irq_q    <= irq_d;
      busy_q   <= busy_d;
    end
  end

  assign irq_o        = irq_q;
  assign pending_o    = pending_q;
  assign ovf_o        = ovf_q;
  assign busy_o       = busy_q;
  assign active_src_o = active_q;

endmodule

// File: tb/tb_irq_pulse_scheduler.sv
// Scoreboard bench: stimulus queues expected pulses, a monitor checks each pulse as it appears.
module tb_irq_pulse_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src;
  logic [7:0] en;
  logic [15:0] map;
  logic       ovf_clr;
  logic [3:0] irq_o;
  logic [7:0] pending_o;
  logic [7:0] ovf_o;
  logic       busy_o;
  logic [2:0] active_src_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         src;
    logic [3:0] irq;
    int         start;
  } exp_t;

  exp_t exp_q[$];

  irq_pulse_scheduler #(
    .NUM_SRC   (8),
    .NUM_IRQ   (4),
    .PULSE_LEN (4),
    .GAP_LEN   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_i        (src),
    .en_i         (en),
    .map_i        (map),
    .ovf_clr_i    (ovf_clr),
    .irq_o        (irq_o),
    .pending_o    (pending_o),
    .ovf_o        (ovf_o),
    .busy_o       (busy_o),
    .active_src_o (active_src_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_map(input int i, input int line);
    logic [1:0] l;
    l = line[1:0];
    map[2*i +: 2] = l;
  endtask

  task automatic expect_pulse(input int s, input logic [3:0] irq, input int start);
    exp_t e;
    e.src   = s;
    e.irq   = irq;
    e.start = start;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    int         hi;
    int         gap;
    logic [3:0] want;
    forever begin
      @(negedge clk);
      if (rst_n && busy_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(busy_o), 32'd0);
          want = irq_o;
        end else begin
          e = exp_q.pop_front();
          check("pulse_src", 32'(active_src_o), e.src);
          check("pulse_line", 32'(irq_o), 32'(e.irq));
          check("pulse_start", cyc, e.start);
          want = e.irq;
        end
        hi = 0;
        while (rst_n && busy_o && irq_o == want && hi < 64) begin
          hi++;
          @(negedge clk);
        end
        gap = 0;
        while (rst_n && busy_o && irq_o == 4'd0 && gap < 64) begin
          gap++;
          @(negedge clk);
        end
        if (rst_n) begin
          check("pulse_len", hi, 4);
          check("gap_len", gap, 2);
        end
      end
    end
  end

  initial begin : stimulus
    int c;
    rst_n   = 1'b0;
    src     = '0;
    en      = 8'hFF;
    map     = '0;
    ovf_clr = 1'b0;
    step(3);
    check("rst_irq", 32'(irq_o), 0);
    check("rst_pending", 32'(pending_o), 0);
    check("rst_ovf", 32'(ovf_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_active", 32'(active_src_o), 0);
    rst_n = 1'b1;
    step(2);

    // Single event: src 3 on line 2.
    set_map(3, 2);
    c = cyc;
    src[3] = 1'b1;
    expect_pulse(3, 4'b0100, c + 2);
    step(1);
    src[3] = 1'b0;
    check("single_pending_set", 32'(pending_o), 32'h08);
    step(12);
    check("single_pending_clr", 32'(pending_o), 0);

    // Simultaneous: src 1 -> line 0 first, src 5 -> line 1 seven cycles later.
    set_map(1, 0);
    set_map(5, 1);
    c = cyc;
    src[1] = 1'b1;
    src[5] = 1'b1;
    expect_pulse(1, 4'b0001, c + 2);
    expect_pulse(5, 4'b0010, c + 9);
    step(1);
    src = '0;
    step(20);

    // Overflow: src 2 rises twice while src 0 is pulsing.
    set_map(0, 3);
    set_map(2, 1);
    c = cyc;
    src[0] = 1'b1;
    expect_pulse(0, 4'b1000, c + 2);
    expect_pulse(2, 4'b0010, c + 9);
    step(1);
    src[0] = 1'b0;
    step(1);
    src[2] = 1'b1;
    step(1);
    src[2] = 1'b0;
    step(1);
    src[2] = 1'b1;
    step(1);
    src[2] = 1'b0;
    step(1);
    check("ovf_set", 32'(ovf_o), 32'h04);
    check("ovf_pending", 32'(pending_o), 32'h04);
    step(14);
    check("ovf_sticky", 32'(ovf_o), 32'h04);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf_o), 0);

    // Masking: disabled rise is dropped; pending src 6 waits for its enable.
    set_map(4, 0);
    en[4]  = 1'b0;
    src[4] = 1'b1;
    step(1);
    src[4] = 1'b0;
    step(3);
    check("mask_no_pending", 32'(pending_o), 0);
    check("mask_no_busy", 32'(busy_o), 0);
    en[4] = 1'b1;
    set_map(6, 3);
    src[6] = 1'b1;
    step(1);
    src[6] = 1'b0;
    en[6]  = 1'b0;
    step(4);
    check("held_pending", 32'(pending_o), 32'h40);
    check("held_not_busy", 32'(busy_o), 0);
    c = cyc;
    en[6] = 1'b1;
    expect_pulse(6, 4'b1000, c + 1);
    step(12);
    check("held_served", 32'(pending_o), 0);

    // Set/clear collision: src 0 rises on the very edge it is granted.
    set_map(1, 1);
    set_map(0, 0);
    c = cyc;
    src[1] = 1'b1;
    expect_pulse(1, 4'b0010, c + 2);
    expect_pulse(0, 4'b0001, c + 9);
    expect_pulse(0, 4'b0001, c + 16);
    step(1);
    src[1] = 1'b0;
    step(1);
    src[0] = 1'b1;
    step(1);
    src[0] = 1'b0;
    step(5);
    src[0] = 1'b1;
    step(1);
    src[0] = 1'b0;
    step(3);
    check("collide_no_ovf", 32'(ovf_o), 0);
    step(20);

    // Reset during the second pulse cycle, with src 6 pending and overflowed.
    set_map(2, 2);
    c = cyc;
    src[2] = 1'b1;
    src[6] = 1'b1;
    expect_pulse(2, 4'b0100, c + 2);
    step(1);
    src = '0;
    step(1);
    src[6] = 1'b1;
    step(1);
    src[6] = 1'b0;
    check("prerst_ovf", 32'(ovf_o), 32'h40);
    check("prerst_pending", 32'(pending_o), 32'h40);
    check("prerst_irq", 32'(irq_o), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_irq", 32'(irq_o), 0);
    check("midrst_pending", 32'(pending_o), 0);
    check("midrst_ovf", 32'(ovf_o), 0);
    check("midrst_busy", 32'(busy_o), 0);
    step(3);
    rst_n = 1'b1;
    step(15);
    check("postrst_pending", 32'(pending_o), 0);
    check("postrst_busy", 32'(busy_o), 0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
